tcam_access_ctrl: RTL

Sequencer and arbiter that shares the single SRAM-style port of `tcam_top` between two requesters: the TL-UL config path (from the SRAM adapter) and a hardware lookup engine. Config accesses pass through as single-cycle operations. Each search is an atomic two-access sequence: key write, then result read. The block sits between `tlul_sram_adapter1`/lookup engine and `tcam_top` inside the TCAM core, and replaces the tied-off `gnt_i` and ad-hoc rvalid logic.

---
 rtl/tcam_pkg.sv | 19 +
 rtl/tcam_access_ctrl_if.sv | 44 ++++
 rtl/tcam_rr_arb2.sv | 36 +++
 rtl/tcam_access_ctrl.sv | 108 ++++++++++
 4 files changed

// File: rtl/tcam_pkg.sv
// Shared types and default addresses for the TCAM access sequencer.
package tcam_pkg;

  typedef enum logic {
    IDLE,
    SRCH_RD
  } state_e;

  localparam logic [31:0] KEY_ADDR_DEFAULT = 32'h0000_1000;
  localparam logic [31:0] RES_ADDR_DEFAULT = 32'h0000_1004;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } tcam_req_t;

endpackage

// File: rtl/tcam_access_ctrl_if.sv
// Bundle of config, search and tcam_top port signals around tcam_access_ctrl.
interface tcam_access_ctrl_if #(
  parameter int unsigned CntW = 16
) ();

  logic            cfg_req_i;
  logic            cfg_gnt_o;
  logic            cfg_we_i;
  logic [31:0]     cfg_addr_i;
  logic [31:0]     cfg_wdata_i;
  logic [3:0]      cfg_wmask_i;
  logic            cfg_rvalid_o;
  logic [31:0]     cfg_rdata_o;
  logic            srch_req_i;
  logic [31:0]     srch_key_i;
  logic            srch_gnt_o;
  logic            srch_valid_o;
  logic [31:0]     srch_result_o;
  logic [CntW-1:0] srch_cnt_o;
  logic            busy_o;
  logic            tcam_csb_o;
  logic            tcam_web_o;
  logic [3:0]      tcam_wmask_o;
  logic [31:0]     tcam_addr_o;
  logic [31:0]     tcam_wdata_o;
  logic [31:0]     tcam_rdata_i;

  modport slave (
    input  cfg_req_i, cfg_we_i, cfg_addr_i, cfg_wdata_i, cfg_wmask_i,
    input  srch_req_i, srch_key_i, tcam_rdata_i,
    output cfg_gnt_o, cfg_rvalid_o, cfg_rdata_o,
    output srch_gnt_o, srch_valid_o, srch_result_o, srch_cnt_o, busy_o,
    output tcam_csb_o, tcam_web_o, tcam_wmask_o, tcam_addr_o, tcam_wdata_o
  );

  modport master (
    output cfg_req_i, cfg_we_i, cfg_addr_i, cfg_wdata_i, cfg_wmask_i,
    output srch_req_i, srch_key_i, tcam_rdata_i,
    input  cfg_gnt_o, cfg_rvalid_o, cfg_rdata_o,
    input  srch_gnt_o, srch_valid_o, srch_result_o, srch_cnt_o, busy_o,
    input  tcam_csb_o, tcam_web_o, tcam_wmask_o, tcam_addr_o, tcam_wdata_o
  );

endinterface

// File: rtl/tcam_rr_arb2.sv
// Two-way round-robin arbiter; index 0 = config, index 1 = search.
module tcam_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  // Remembers the last winner; resets to "search won" so config is favoured first.
  logic last_q, last_d;

  always_comb begin
    gnt_o  = '0;
    last_d = last_q;
    if (en_i) begin
      if (req_i == 2'b11) begin
        gnt_o = last_q ? 2'b01 : 2'b10;
      end else begin
        gnt_o = req_i;
      end
      if (gnt_o != 2'b00) begin
        last_d = gnt_o[1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/tcam_access_ctrl.sv
// Shares the tcam_top SRAM port between config accesses and atomic
// key-write/result-read search sequences.
module tcam_access_ctrl
  import tcam_pkg::*;
#(
  parameter logic [31:0] KeyAddr = KEY_ADDR_DEFAULT,
  parameter logic [31:0] ResAddr = RES_ADDR_DEFAULT,
  parameter int unsigned CntW    = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  tcam_access_ctrl_if.slave  bus
);

  state_e          state_q, state_d;
  logic            rvalid_q, rvalid_d;
  logic            cap_q, cap_d;
  logic            valid_q, valid_d;
  logic [31:0]     result_q, result_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [1:0]      gnt;
  logic            csb;
  tcam_req_t       tcam_req;

  tcam_rr_arb2 u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (state_q == IDLE),
    .req_i  ({bus.srch_req_i, bus.cfg_req_i}),
    .gnt_o  (gnt)
  );

  always_comb begin
    state_d  = state_q;
    rvalid_d = 1'b0;
    cap_d    = 1'b0;
    valid_d  = 1'b0;
    result_d = result_q;
    cnt_d    = cnt_q;
    csb      = 1'b1;
    tcam_req = '0;

    case (state_q)
      IDLE: begin
        if (gnt[0]) begin
          csb      = 1'b0;
          tcam_req = '{we: bus.cfg_we_i, addr: bus.cfg_addr_i,
                       wdata: bus.cfg_wdata_i, wmask: bus.cfg_wmask_i};
          rvalid_d = ~bus.cfg_we_i;
        end else if (gnt[1]) begin
          csb      = 1'b0;
          tcam_req = '{we: 1'b1, addr: KeyAddr, wdata: bus.srch_key_i, wmask: 4'hF};
          state_d  = SRCH_RD;
        end
      end
      SRCH_RD: begin
        csb           = 1'b0;
        tcam_req.addr = ResAddr;
        cap_d         = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Result read data arrives one cycle after the SRCH_RD issue.
    if (cap_q) begin
      result_d = bus.tcam_rdata_i;
      valid_d  = 1'b1;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rvalid_q <= 1'b0;
      cap_q    <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= rvalid_d;
      cap_q    <= cap_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.cfg_gnt_o     = gnt[0];
  assign bus.srch_gnt_o    = gnt[1];
  assign bus.cfg_rvalid_o  = rvalid_q;
  assign bus.cfg_rdata_o   = rvalid_q ? bus.tcam_rdata_i : '0;
  assign bus.srch_valid_o  = valid_q;
  assign bus.srch_result_o = result_q;
  assign bus.srch_cnt_o    = cnt_q;
  assign bus.busy_o        = (state_q != IDLE);
  assign bus.tcam_csb_o    = csb;
  assign bus.tcam_web_o    = ~tcam_req.we;
  assign bus.tcam_wmask_o  = tcam_req.wmask;
  assign bus.tcam_addr_o   = tcam_req.addr;
  assign bus.tcam_wdata_o  = tcam_req.wdata;

endmodule
